sensor_debouncer: RTL and testbench
===================================

Name: sensor_debouncer

Overview:
- Multi-channel debouncer for door/window/PIR sensor and keypad inputs of the alarm system.
- Sits directly downstream of the 20 ms timer and consumes its terminal-count output as a sample tick.
- Commits a new level only after STABLE_TICKS consecutive agreeing tick samples.
- Emits one-clock rise/fall strobes to the alarm control FSM.

Parameters:
- CHANNELS, 4: number of independent raw inputs.
- STABLE_TICKS, 3: consecutive agreeing tick samples needed to commit a change; legal range 1..(2^CNT_W)-1.
- CNT_W, 4: width of each per-channel pending counter.

Ports:
- clock50  input  1  system clock, 50 MHz.
- Mr  input  1  master reset, asynchronous, active-low.
- tick  input  1  20 ms terminal count from the timer; may be a one-clock pulse or a held (latched) level.
- raw_in  input  CHANNELS  asynchronous raw sensor/switch inputs.
- level  output  CHANNELS  debounced, committed level per channel.
- rise  output  CHANNELS  one-clock strobe when a channel commits 0->1.
- fall  output  CHANNELS  one-clock strobe when a channel commits 1->0.
- any_change  output  1  registered OR of all rise and fall bits, cycle-aligned with them.

Behaviour:
- Reset (Mr low, async):
  - all channel FSMs go to STABLE_LO; counters 0; synchronizer flops 0.
  - level, rise, fall, any_change = 0; tick_d = 1.
- tick_d = 1 at reset stops a tick already high at reset release from creating a strobe.
- Tick handling:
  - tick_d registers tick.
  - tick_stb = tick & ~tick_d: exactly one strobe per tick rising edge, even if tick is held high for many clocks.
- Input sync: each raw_in bit passes through a 2-flop synchronizer; FSMs see only the synchronized bit s.
- Per-channel FSM (2-bit state) updates only on clocks where tick_stb = 1; otherwise it holds.
  - STABLE_LO: s = 1 -> cnt = 1; if STABLE_TICKS = 1, commit high this clock, else go to PEND_HI. s = 0 -> stay.
  - PEND_HI: s = 1 -> cnt + 1; when it reaches STABLE_TICKS, commit high (go to STABLE_HI, level = 1, rise = 1, cnt = 0). s = 0 -> abort to STABLE_LO, cnt = 0, no strobe.
  - STABLE_HI and PEND_LO: mirror image, committing low with fall = 1.
- Strobes:
  - rise/fall are registered and asserted for exactly the one clock after the committing edge; cleared the following clock.
  - any_change goes high in the same cycle as any rise/fall bit.
- Latency:
  - raw edge -> s: 2 clocks.
  - s stable -> commit: on the STABLE_TICKS-th tick_stb that samples the new value.
  - level, rise, fall update on that same edge.
- Boundaries:
  - Bounce between strobes is invisible; only tick samples count.
  - A disagreeing sample while pending aborts and clears cnt.
  - rise and fall are never both set on one channel in the same cycle.
  - Channels are independent; several may commit on the same tick.
  - cnt never exceeds STABLE_TICKS, so no wrap.
  - Mr asserted mid-pending discards the pending change with no strobe.
  - raw_in changing on the same clock as tick_stb is judged by the already-synchronized s.

Decomposition:
- Shared include alarm_defs.vh holds:
  - state encodings STABLE_LO = 2'b00, PEND_HI = 2'b01, STABLE_HI = 2'b11, PEND_LO = 2'b10;
  - default STABLE_TICKS.
- Sub-module debounce_channel: synchronizer, FSM, counter, and level/rise/fall flops for one bit.
- Top level holds the tick edge detector and the any_change register, and instantiates debounce_channel CHANNELS times in a generate loop.

Test Plan (CHANNELS = 4, STABLE_TICKS = 3; bench drives a tick pulse every 10 clocks to shorten sim):
- Reset: Mr low with raw_in = 4'hF, then release -> level = 0, rise = fall = any_change = 0; level = 4'hF only after the 3rd tick strobe; rise = 4'hF and any_change = 1 for exactly 1 clock.
- Bounce abort: raw_in[0] high for 2 ticks, low at the 3rd, then high for 3 ticks -> no strobe on the first attempt; exactly one rise[0] after the 5th-6th tick sequence completes.
- Held tick: tick held high for 50 clocks while raw_in[1] rises -> that tick counts as one sample only; commit needs 2 further tick rising edges.
- Sub-tick glitch: raw_in[2] pulses high for 4 clocks entirely between two tick strobes -> level[2] stays 0; no rise, no any_change.
- Simultaneous events: raw_in[3] falls while raw_in[0] rises on the same clock -> after 3 ticks, rise = 4'b0001 and fall = 4'b1000 in the same cycle; any_change = 1 once.
- Reset mid-pending: assert Mr after 2 agreeing ticks on channel 1, then release -> state STABLE_LO, level[1] = 0, no strobe; a re-count from 0 is required.

Source files
------------

// File: rtl/sensor_debouncer_pkg.sv
// Shared definitions for the alarm-system sensor debouncer: channel state
// encodings and default sizing.
package sensor_debouncer_pkg;

  localparam int unsigned DEF_CHANNELS     = 4;
  localparam int unsigned DEF_STABLE_TICKS = 3;
  localparam int unsigned DEF_CNT_W        = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } deb_state_e;

endpackage

// File: rtl/sensor_debouncer_debounce_channel.sv
// One debounced bit: 2-flop synchronizer, tick-sampled stability FSM with
// pending counter, and registered level/rise/fall.
module debounce_channel
  import sensor_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic clock50,
  input  logic Mr,
  input  logic tick_stb,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change_c
);

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             sync_meta;
  logic             s;
  deb_state_e       state;
  deb_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             level_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  // Metastability guard for the asynchronous sensor input
  always_ff @(posedge clock50 or negedge Mr) begin
    if (!Mr) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
    end else begin
      sync_meta <= raw;
      s         <= sync_meta;
    end
  end

  always_ff @(posedge clock50 or negedge Mr) begin
    if (!Mr) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // cnt is 0 in both stable states, so the first disagreeing sample gives
  // cnt_inc = 1 and STABLE_TICKS = 1 commits immediately.
  assign cnt_inc = cnt + CNT_ONE;
  assign hit     = (cnt_inc == CNT_TARGET);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (tick_stb) begin
      case (state)
        STABLE_LO, PEND_HI: begin
          if (s) begin
            if (hit) begin
              state_nxt = STABLE_HI;
              cnt_nxt   = '0;
              level_nxt = 1'b1;
              rise_nxt  = 1'b1;
            end else begin
              state_nxt = PEND_HI;
              cnt_nxt   = cnt_inc;
            end
          end else begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
          end
        end
        STABLE_HI, PEND_LO: begin
          if (!s) begin
            if (hit) begin
              state_nxt = STABLE_LO;
              cnt_nxt   = '0;
              level_nxt = 1'b0;
              fall_nxt  = 1'b1;
            end else begin
              state_nxt = PEND_LO;
              cnt_nxt   = cnt_inc;
            end
          end else begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign change_c = rise_nxt | fall_nxt;

endmodule

// File: rtl/sensor_debouncer.sv
// Multi-channel sensor/keypad debouncer: turns the 20 ms timer tick into a
// single-clock sample strobe and debounces each raw input against it.
module sensor_debouncer
  import sensor_debouncer_pkg::*;
#(
  parameter int unsigned CHANNELS     = DEF_CHANNELS,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                clock50,
  input  logic                Mr,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  logic                tick_d;
  logic                tick_stb_c;
  logic [CHANNELS-1:0] change_c;

  // tick_d resets high so a tick already asserted at reset release is ignored
  always_ff @(posedge clock50 or negedge Mr) begin
    if (!Mr) begin
      tick_d <= 1'b1;
    end else begin
      tick_d <= tick;
    end
  end

  assign tick_stb_c = tick & ~tick_d;

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clock50 (clock50),
      .Mr      (Mr),
      .tick_stb(tick_stb_c),
      .raw     (raw_in[g]),
      .level   (level[g]),
      .rise    (rise[g]),
      .fall    (fall[g]),
      .change_c(change_c[g])
    );
  end

  // Built from the channels' next-strobe terms so it lands with rise/fall
  always_ff @(posedge clock50 or negedge Mr) begin
    if (!Mr) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |change_c;
    end
  end

endmodule

// File: tb/tb_sensor_debouncer.sv
// Bench for sensor_debouncer: directed vector table, hand-written corner
// sequences, and random stimulus against a cycle-level reference model.
module tb_sensor_debouncer;

  localparam int unsigned CH = 4;
  localparam int unsigned ST = 3;
  localparam int unsigned CW = 4;

  logic          clock50 = 1'b0;
  logic          Mr;
  logic          tick;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          any_change;

  int errors = 0;
  int checks = 0;

  always #5 clock50 = ~clock50;

  sensor_debouncer #(
    .CHANNELS    (CH),
    .STABLE_TICKS(ST),
    .CNT_W       (CW)
  ) dut (
    .clock50   (clock50),
    .Mr        (Mr),
    .tick      (tick),
    .raw_in    (raw_in),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel commits once ST consecutive strobe samples of
  // the 2-clock-delayed input differ from its committed level.
  logic [CH-1:0] m_sync1 = '0, m_sync2 = '0, m_level = '0, m_rise = '0, m_fall = '0;
  logic          m_tick_d = 1'b1, m_any = 1'b0;
  int            m_pcnt[CH];

  always @(posedge clock50 or negedge Mr) begin : model
    logic          stb;
    logic [CH-1:0] lv, r, f;
    int            pc[CH];
    if (!Mr) begin
      m_sync1  <= '0;
      m_sync2  <= '0;
      m_tick_d <= 1'b1;
      m_level  <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_any    <= 1'b0;
      for (int c = 0; c < CH; c++) m_pcnt[c] <= 0;
    end else begin
      stb = tick && !m_tick_d;
      lv  = m_level;
      r   = '0;
      f   = '0;
      pc  = m_pcnt;
      if (stb) begin
        for (int c = 0; c < CH; c++) begin
          if (m_sync2[c] != lv[c]) begin
            pc[c]++;
            if (pc[c] == ST) begin
              lv[c] = m_sync2[c];
              if (m_sync2[c]) r[c] = 1'b1;
              else            f[c] = 1'b1;
              pc[c] = 0;
            end
          end else begin
            pc[c] = 0;
          end
        end
      end
      m_tick_d <= tick;
      m_sync2  <= m_sync1;
      m_sync1  <= raw_in;
      m_level  <= lv;
      m_rise   <= r;
      m_fall   <= f;
      m_any    <= |(r | f);
      m_pcnt   <= pc;
    end
  end

  // Per-cycle scoreboard plus strobe accumulators for the directed steps
  logic [CH-1:0] acc_rise, acc_fall;
  int            any_cyc, rise_cyc;

  always @(negedge clock50) begin
    chk("sb_level", 32'(level), 32'(m_level));
    chk("sb_rise", 32'(rise), 32'(m_rise));
    chk("sb_fall", 32'(fall), 32'(m_fall));
    chk("sb_any", 32'(any_change), 32'(m_any));
    acc_rise = acc_rise | rise;
    acc_fall = acc_fall | fall;
    if (any_change) any_cyc++;
    if (rise != '0) rise_cyc++;
  end

  task automatic clr_acc();
    acc_rise = '0;
    acc_fall = '0;
    any_cyc  = 0;
    rise_cyc = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock50);
    #1;
  endtask

  task automatic tick_period();
    cyc(5);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(4);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick_period();
  endtask

  typedef struct {
    logic [CH-1:0] raw;
    int            ticks;
    logic [CH-1:0] lvl;
    logic [CH-1:0] r;
    logic [CH-1:0] f;
    int            anyc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{4'hE, 3, 4'hE, 4'h0, 4'h1, 1};
    tbl[1]  = '{4'hF, 2, 4'hE, 4'h0, 4'h0, 0};
    tbl[2]  = '{4'hE, 1, 4'hE, 4'h0, 4'h0, 0};
    tbl[3]  = '{4'hF, 2, 4'hE, 4'h0, 4'h0, 0};
    tbl[4]  = '{4'hF, 1, 4'hF, 4'h1, 4'h0, 1};
    tbl[5]  = '{4'hE, 3, 4'hE, 4'h0, 4'h1, 1};
    tbl[6]  = '{4'h7, 3, 4'h7, 4'h1, 4'h8, 1};
    tbl[7]  = '{4'h0, 3, 4'h0, 4'h0, 4'h7, 1};
    tbl[8]  = '{4'h5, 2, 4'h0, 4'h0, 4'h0, 0};
    tbl[9]  = '{4'h5, 1, 4'h5, 4'h5, 4'h0, 1};
    tbl[10] = '{4'h0, 3, 4'h0, 4'h0, 4'h5, 1};

    clr_acc();
    Mr     = 1'b0;
    tick   = 1'b0;
    raw_in = 4'hF;
    cyc(3);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_rise", 32'(rise), 32'h0);
    chk("rst_fall", 32'(fall), 32'h0);
    chk("rst_any", 32'(any_change), 32'h0);

    // Reset release with all inputs high: commit on the 3rd strobe only
    Mr = 1'b1;
    cyc(2);
    clr_acc();
    run_ticks(2);
    chk("rel_level_2t", 32'(level), 32'h0);
    tick_period();
    chk("rel_level_3t", 32'(level), 32'hF);
    chk("rel_rise_or", 32'(acc_rise), 32'hF);
    chk("rel_rise_cycles", 32'(rise_cyc), 32'd1);
    chk("rel_any_cycles", 32'(any_cyc), 32'd1);

    for (int i = 0; i < 11; i++) begin
      raw_in = tbl[i].raw;
      clr_acc();
      run_ticks(tbl[i].ticks);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_rise", i), 32'(acc_rise), 32'(tbl[i].r));
      chk($sformatf("vec%0d_fall", i), 32'(acc_fall), 32'(tbl[i].f));
      chk($sformatf("vec%0d_any", i), 32'(any_cyc), 32'(tbl[i].anyc));
    end

    // Glitch on channel 2 entirely between two strobes
    clr_acc();
    raw_in = 4'h4;
    cyc(4);
    raw_in = 4'h0;
    run_ticks(3);
    chk("glitch_level", 32'(level), 32'h0);
    chk("glitch_rise", 32'(acc_rise), 32'h0);
    chk("glitch_any", 32'(any_cyc), 32'd0);

    // Held tick counts as a single sample
    clr_acc();
    raw_in = 4'h2;
    cyc(3);
    tick = 1'b1;
    cyc(50);
    tick = 1'b0;
    chk("held_level_hold", 32'(level), 32'h0);
    chk("held_any_hold", 32'(any_cyc), 32'd0);
    tick_period();
    chk("held_level_1", 32'(level), 32'h0);
    tick_period();
    chk("held_level_2", 32'(level), 32'h2);
    chk("held_rise", 32'(acc_rise), 32'h2);
    chk("held_any", 32'(any_cyc), 32'd1);

    // Reset in the middle of a pending change discards it
    raw_in = 4'h0;
    run_ticks(3);
    chk("mid_pre_level", 32'(level), 32'h0);
    raw_in = 4'h2;
    clr_acc();
    run_ticks(2);
    Mr = 1'b0;
    cyc(2);
    Mr = 1'b1;
    chk("mid_rst_level", 32'(level), 32'h0);
    chk("mid_rst_any", 32'(any_cyc), 32'd0);
    run_ticks(2);
    chk("mid_recount_level", 32'(level), 32'h0);
    tick_period();
    chk("mid_commit_level", 32'(level), 32'h2);
    chk("mid_commit_rise", 32'(acc_rise), 32'h2);
    chk("mid_commit_any", 32'(any_cyc), 32'd1);

    // Random raw inputs, pulsed/held ticks and rare resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) raw_in = CH'($urandom);
      if ($urandom_range(0, 5) == 0) tick = ~tick;
      Mr = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    Mr = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
